riscv_id_ex_stage: RTL

- ID/EX pipeline register and operand-select stage feeding the EX-stage ALU.
- Captures decoded instructions from ID and applies register bypass at capture.
- Resolves EX operands with EX/MEM and MEM/WB forwarding, then drives the ALU control, A and B operands, plus store data and writeback control to later stages.
- Detects load-use hazards, inserts bubbles and handles downstream hold and branch flush.

---
 rtl/riscv_id_ex_stage_pkg.sv | 29 ++
 rtl/riscv_fwd_mux.sv | 34 +++
 rtl/riscv_id_ex_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_id_ex_stage_pkg.sv
// Shared definitions for the ID/EX operand-select stage.
// Holds the default datapath widths, the A/B operand select encodings
// and the ID/EX register state encoding.
package riscv_id_ex_stage_pkg;

    // Default widths: RegBus, AluctrBus and register address
    localparam int XLEN_DEF     = 32;
    localparam int ALUCTR_W_DEF = 4;
    localparam int REG_AW_DEF   = 5;

    // ALU operand A source
    localparam logic A_SEL_RS1 = 1'b0;
    localparam logic A_SEL_PC  = 1'b1;

    // ALU operand B source
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    // ALU control value left in an empty register (add)
    localparam logic [3:0] ALU_ADD = 4'b0000;

    // ID/EX register occupancy
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,   // bubble
        ST_ACTIVE = 2'd1,   // valid instruction, advancing
        ST_HELD   = 2'd2    // valid instruction, frozen by downstream hold
    } id_ex_state_e;

endpackage

// File: rtl/riscv_fwd_mux.sv
// riscv_fwd_mux: per-operand forwarding priority mux.
// EX/MEM result wins over MEM/WB result, which wins over the registered
// value. Register x0 is never forwarded.
module riscv_fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic              exmem_fwd_en_i,
    input  logic [REG_AW-1:0] exmem_rd_addr_i,
    input  logic [XLEN-1:0]   exmem_result_i,
    input  logic              memwb_fwd_en_i,
    input  logic [REG_AW-1:0] memwb_rd_addr_i,
    input  logic [XLEN-1:0]   memwb_result_i,
    output logic [XLEN-1:0]   fwd_data_o
);

    logic exmem_hit;
    logic memwb_hit;

    // Select the youngest in-flight producer of this source register
    always_comb begin
        exmem_hit  = exmem_fwd_en_i && (exmem_rd_addr_i != '0) && (exmem_rd_addr_i == rs_addr_i);
        memwb_hit  = memwb_fwd_en_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == rs_addr_i);
        fwd_data_o = rs_data_i;
        if (exmem_hit) begin
            fwd_data_o = exmem_result_i;
        end else if (memwb_hit) begin
            fwd_data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/riscv_id_ex_stage.sv
// riscv_id_ex_stage: ID/EX pipeline register and EX operand select.
// Captures the decoded instruction (with MEM/WB bypass of the regfile
// read), forwards EX operands from EX/MEM and MEM/WB, and inserts bubbles
// for load-use hazards, flushes and downstream holds.
// Optional feature macro RISCV_FWD_EN: when defined, EX-side forwarding
// and load-use detection are enabled; when undefined, there is no EX-side
// forwarding and ID stalls on any RAW dependency against EX or EX/MEM.
module riscv_id_ex_stage
    import riscv_id_ex_stage_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ALUCTR_W = ALUCTR_W_DEF,
    parameter int REG_AW   = REG_AW_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                id_valid_i,
    input  logic [XLEN-1:0]     id_pc_i,
    input  logic [REG_AW-1:0]   id_rs1_addr_i,
    input  logic [REG_AW-1:0]   id_rs2_addr_i,
    input  logic                id_rs1_used_i,
    input  logic                id_rs2_used_i,
    input  logic [XLEN-1:0]     id_rs1_data_i,
    input  logic [XLEN-1:0]     id_rs2_data_i,
    input  logic [XLEN-1:0]     id_imm_i,
    input  logic [ALUCTR_W-1:0] id_alu_ctr_i,
    input  logic                id_a_sel_i,
    input  logic                id_b_sel_i,
    input  logic [REG_AW-1:0]   id_rd_addr_i,
    input  logic                id_rd_we_i,
    input  logic                id_mem_rd_i,
    input  logic                id_mem_wr_i,
    input  logic [REG_AW-1:0]   exmem_rd_addr_i,
    input  logic                exmem_rd_we_i,
    input  logic                exmem_is_load_i,
    input  logic [XLEN-1:0]     exmem_result_i,
    input  logic [REG_AW-1:0]   memwb_rd_addr_i,
    input  logic                memwb_rd_we_i,
    input  logic [XLEN-1:0]     memwb_result_i,
    input  logic                flush_i,
    input  logic                mem_stall_i,
    output logic                stall_id_o,
    output logic                ex_valid_o,
    output logic [XLEN-1:0]     ex_pc_o,
    output logic [ALUCTR_W-1:0] ex_alu_ctr_o,
    output logic [XLEN-1:0]     ex_alu_a_o,
    output logic [XLEN-1:0]     ex_alu_b_o,
    output logic [XLEN-1:0]     ex_store_data_o,
    output logic [REG_AW-1:0]   ex_rd_addr_o,
    output logic                ex_rd_we_o,
    output logic                ex_mem_rd_o,
    output logic                ex_mem_wr_o
);

    // ID/EX register
    id_ex_state_e        state_q,    state_d;
    logic [XLEN-1:0]     pc_q,       pc_d;
    logic [REG_AW-1:0]   rs1_addr_q, rs1_addr_d;
    logic [REG_AW-1:0]   rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0]     rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]     rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]     imm_q,      imm_d;
    logic [ALUCTR_W-1:0] alu_ctr_q,  alu_ctr_d;
    logic                a_sel_q,    a_sel_d;
    logic                b_sel_q,    b_sel_d;
    logic [REG_AW-1:0]   rd_addr_q,  rd_addr_d;
    logic                rd_we_q,    rd_we_d;
    logic                mem_rd_q,   mem_rd_d;
    logic                mem_wr_q,   mem_wr_d;

    logic                ex_valid;
    logic                ex_rd_we;
    logic                hazard;
    logic                exmem_fwd_en;
    logic                memwb_fwd_en;
    logic [XLEN-1:0]     fwd_rs1;
    logic [XLEN-1:0]     fwd_rs2;
    logic [XLEN-1:0]     rs1_cap;
    logic [XLEN-1:0]     rs2_cap;

    assign ex_valid = (state_q != ST_EMPTY);
    // A write to x0 never reaches the regfile, so it is never a producer
    assign ex_rd_we = rd_we_q && (rd_addr_q != '0);

`ifdef RISCV_FWD_EN
    // A load result is not available from EX/MEM; it must go through MEM/WB
    assign exmem_fwd_en = exmem_rd_we_i && !exmem_is_load_i;
    assign memwb_fwd_en = memwb_rd_we_i;

    // Load-use: ID consumes the register a load in EX is about to fetch
    always_comb begin
        hazard = id_valid_i && ex_valid && mem_rd_q && (rd_addr_q != '0) &&
                 ((id_rs1_used_i && (id_rs1_addr_i == rd_addr_q)) ||
                  (id_rs2_used_i && (id_rs2_addr_i == rd_addr_q)));
    end
`else
    logic unused_is_load;
    assign unused_is_load = exmem_is_load_i;
    assign exmem_fwd_en   = 1'b0;
    assign memwb_fwd_en   = 1'b0;

    // Without EX forwarding, wait until any producer in EX or EX/MEM has reached MEM/WB
    always_comb begin
        hazard = id_valid_i &&
                 ((id_rs1_used_i && (id_rs1_addr_i != '0) &&
                   ((ex_rd_we && (id_rs1_addr_i == rd_addr_q)) ||
                    (exmem_rd_we_i && (id_rs1_addr_i == exmem_rd_addr_i)))) ||
                  (id_rs2_used_i && (id_rs2_addr_i != '0) &&
                   ((ex_rd_we && (id_rs2_addr_i == rd_addr_q)) ||
                    (exmem_rd_we_i && (id_rs2_addr_i == exmem_rd_addr_i)))));
    end
`endif

    riscv_fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd_rs1 (
        .rs_addr_i       (rs1_addr_q),
        .rs_data_i       (rs1_data_q),
        .exmem_fwd_en_i  (exmem_fwd_en),
        .exmem_rd_addr_i (exmem_rd_addr_i),
        .exmem_result_i  (exmem_result_i),
        .memwb_fwd_en_i  (memwb_fwd_en),
        .memwb_rd_addr_i (memwb_rd_addr_i),
        .memwb_result_i  (memwb_result_i),
        .fwd_data_o      (fwd_rs1)
    );

    riscv_fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd_rs2 (
        .rs_addr_i       (rs2_addr_q),
        .rs_data_i       (rs2_data_q),
        .exmem_fwd_en_i  (exmem_fwd_en),
        .exmem_rd_addr_i (exmem_rd_addr_i),
        .exmem_result_i  (exmem_result_i),
        .memwb_fwd_en_i  (memwb_fwd_en),
        .memwb_rd_addr_i (memwb_rd_addr_i),
        .memwb_result_i  (memwb_result_i),
        .fwd_data_o      (fwd_rs2)
    );

    // Regfile read bypass: a MEM/WB write in the same cycle is not yet visible in the regfile
    always_comb begin
        rs1_cap = id_rs1_data_i;
        rs2_cap = id_rs2_data_i;
        if (memwb_rd_we_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == id_rs1_addr_i)) begin
            rs1_cap = memwb_result_i;
        end
        if (memwb_rd_we_i && (memwb_rd_addr_i != '0) && (memwb_rd_addr_i == id_rs2_addr_i)) begin
            rs2_cap = memwb_result_i;
        end
    end

    // Next register contents: hold > flush > hazard bubble > capture
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        alu_ctr_d  = alu_ctr_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        if (mem_stall_i) begin
            // Frozen, but operands are refreshed so they survive the producer retiring
            state_d    = (state_q == ST_EMPTY) ? ST_EMPTY : ST_HELD;
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end else begin
            // Data fields load on every advancing edge; a bubble only clears control
            pc_d       = id_pc_i;
            rs1_addr_d = id_rs1_addr_i;
            rs2_addr_d = id_rs2_addr_i;
            rs1_data_d = rs1_cap;
            rs2_data_d = rs2_cap;
            imm_d      = id_imm_i;
            alu_ctr_d  = id_alu_ctr_i;
            a_sel_d    = id_a_sel_i;
            b_sel_d    = id_b_sel_i;
            rd_addr_d  = id_rd_addr_i;
            if (flush_i || hazard) begin
                state_d  = ST_EMPTY;
                rd_we_d  = 1'b0;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end else begin
                state_d  = id_valid_i ? ST_ACTIVE : ST_EMPTY;
                rd_we_d  = id_valid_i && id_rd_we_i;
                mem_rd_d = id_valid_i && id_mem_rd_i;
                mem_wr_d = id_valid_i && id_mem_wr_i;
            end
        end
    end

    // ID/EX register with asynchronous clear to an empty add bubble
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_EMPTY;
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            alu_ctr_q  <= ALUCTR_W'(ALU_ADD);
            a_sel_q    <= A_SEL_RS1;
            b_sel_q    <= B_SEL_RS2;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            alu_ctr_q  <= alu_ctr_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign stall_id_o      = (hazard && !flush_i) || mem_stall_i;
    assign ex_valid_o      = ex_valid;
    assign ex_pc_o         = pc_q;
    assign ex_alu_ctr_o    = alu_ctr_q;
    assign ex_alu_a_o      = (a_sel_q == A_SEL_PC)  ? pc_q  : fwd_rs1;
    assign ex_alu_b_o      = (b_sel_q == B_SEL_IMM) ? imm_q : fwd_rs2;
    assign ex_store_data_o = fwd_rs2;
    assign ex_rd_addr_o    = rd_addr_q;
    assign ex_rd_we_o      = ex_rd_we;
    assign ex_mem_rd_o     = mem_rd_q;
    assign ex_mem_wr_o     = mem_wr_q;

endmodule
